prescaled_counter: RTL and testbench
====================================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 1..32.
REQ-002 Parameter DIV, default 50000000: prescaler period in clock cycles, legal range 1..2^27; prescaler register width is clog2(DIV), minimum 1 bit.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 count_e  input  1  count enable, sampled only on tick cycles.
REQ-006 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 clear  input  1  synchronous clear of counter and prescaler.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value loaded when load=1.
REQ-010 count  output  WIDTH  registered counter value.
REQ-011 tick  output  1  registered one-cycle prescaler strobe.
REQ-012 wrap  output  1  registered one-cycle pulse on a boundary event (wrap, or saturation hit when saturation is enabled).

Function
REQ-013 All logic is in the clock domain; no derived or gated clocks; the prescaler acts only as a clock enable.
REQ-014 Prescaler counts 0..DIV-1 and returns to 0; tick=1 in the cycle after the prescaler holds DIV-1, and is 0 otherwise.
REQ-015 DIV=1: tick=1 every cycle after reset release.
REQ-016 Priority per cycle: clear > load > (tick & count_e) > hold.
REQ-017 clear=1: count=0, prescaler=0, tick=0 and wrap=0 on the next edge.
REQ-018 load=1 (clear=0): count=load_val on the next edge, independent of tick; wrap=0; prescaler keeps running.
REQ-019 On a tick cycle with count_e=1: count steps by +1 (up_dn=1) or -1 (up_dn=0) modulo 2^WIDTH; the new value is visible one cycle later.
REQ-020 count holds when tick=0 or count_e=0.
REQ-021 In wrap mode, wrap=1 for exactly one cycle, coincident with the update, when count goes from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down).
REQ-022 A direction change takes effect on the next qualifying tick; there is no pipeline hazard.
REQ-023 Arithmetic is unsigned WIDTH-bit; load_val is taken verbatim.

Reset
REQ-024 While reset=0: count=0, prescaler=0, tick=0, wrap=0, applied immediately without waiting for a clock edge.
REQ-025 Reset asserted mid-count aborts the step in progress; after release the first tick occurs DIV cycles later.

Configuration
REQ-026 Macro COUNTER_SATURATE_EN: when defined, the counter saturates and does not wrap.
REQ-027 With COUNTER_SATURATE_EN defined:
- Up at 2^WIDTH-1 holds at 2^WIDTH-1.
- Down at 0 holds at 0.
- wrap pulses one cycle on the step that first reaches the limit and stays 0 while the counter sits at the limit.
REQ-028 Without COUNTER_SATURATE_EN, the wrap-mode behaviour of REQ-019 and REQ-021 applies, and no saturation logic is synthesised.

Verification (WIDTH=4, DIV=3 unless noted)
REQ-029 Reset release, count_e=1, up_dn=1 for 12 cycles -> tick on cycles 3, 6, 9, 12; count=1, 2, 3, 4 one cycle after each tick.
REQ-030 load=1, load_val=14, then count up for 2 ticks -> 15, then 0 with wrap=1 for one cycle; with COUNTER_SATURATE_EN -> 15, 15, wrap pulse only on the 14->15 step.
REQ-031 count=0, up_dn=0, one tick -> count=15 and wrap=1; with COUNTER_SATURATE_EN -> count=0, wrap=0.
REQ-032 clear=1 and load=1 in the same cycle as a tick -> count=0, next tick 3 cycles later.
REQ-033 reset driven to 0 between clock edges with count=9 -> count=0 immediately, with no clock edge required.
REQ-034 DIV=1, count_e toggling 1,0,1,1 -> count=1, 1, 2, 3.

Source files
------------

// File: rtl/prescaled_counter.sv
// Prescaled up/down counter with synchronous clear/load.
// A free-running prescaler produces a one-cycle tick every DIV clocks; the
// counter steps only on tick cycles with count_e set.
// Optional build macro: COUNTER_SATURATE_EN (saturate at the limits instead of
// wrapping; the wrap output then flags the step that first reaches a limit).
module prescaled_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 50000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             count_e,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [PRE_W-1:0] pre;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;

  // Prescaler: counts 0..DIV-1; tick is registered so it appears the cycle
  // after the prescaler holds DIV-1. Clear restarts the period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (pre == PRE_LAST) begin
      pre  <= '0;
      tick <= 1'b1;
    end else begin
      pre  <= pre + PRE_W'(1);
      tick <= 1'b0;
    end
  end

  // Next counter value and boundary flag for a qualifying step.
  always_comb begin
    step_val  = count;
    step_wrap = 1'b0;
`ifdef COUNTER_SATURATE_EN
    if (up_dn) begin
      if (count != CNT_MAX) begin
        step_val  = count + CNT_ONE;
        step_wrap = (count + CNT_ONE) == CNT_MAX;
      end
    end else begin
      if (count != CNT_ZERO) begin
        step_val  = count - CNT_ONE;
        step_wrap = (count - CNT_ONE) == CNT_ZERO;
      end
    end
`else
    if (up_dn) begin
      step_val  = count + CNT_ONE;
      step_wrap = (count == CNT_MAX);
    end else begin
      step_val  = count - CNT_ONE;
      step_wrap = (count == CNT_ZERO);
    end
`endif
  end

  // Counter register: clear > load > tick&count_e > hold; wrap is a one-cycle pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (tick && count_e) begin
      count <= step_val;
      wrap  <= step_wrap;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed, table-driven bench for prescaled_counter (WIDTH=4, DIV=3 and DIV=1).
module tb_prescaled_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic       ce;
    logic       ud;
    logic       cl;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] e_count;
    logic       e_tick;
    logic       e_wrap;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       count_e, up_dn, clear, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tick, wrap;
  logic       count_e_b;
  logic [3:0] count_b;
  logic       tick_b, wrap_b;

  int passed = 0;
  int total  = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  prescaled_counter #(.WIDTH(4), .DIV(3)) dut_a (
    .clock(clock), .reset(reset), .count_e(count_e), .up_dn(up_dn),
    .clear(clear), .load(load), .load_val(load_val),
    .count(count), .tick(tick), .wrap(wrap)
  );

  prescaled_counter #(.WIDTH(4), .DIV(1)) dut_b (
    .clock(clock), .reset(reset), .count_e(count_e_b), .up_dn(up_dn),
    .clear(clear), .load(load), .load_val(load_val),
    .count(count_b), .tick(tick_b), .wrap(wrap_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic ce, input logic ud, input logic cl, input logic ld,
                     input logic [3:0] lv, input logic [3:0] ec, input logic et,
                     input logic ew);
    vec_t v;
    v.ce = ce; v.ud = ud; v.cl = cl; v.ld = ld; v.lv = lv;
    v.e_count = ec; v.e_tick = et; v.e_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] sat15_or_0;
    logic [3:0] dn_val;
    logic       b_ce[5];
    logic [3:0] b_cnt[5];
    logic       a_tick[5];
    logic [3:0] a_cnt[5];

    sat15_or_0 = SAT ? 4'd15 : 4'd0;
    dn_val     = SAT ? 4'd0  : 4'd15;

    // count up from reset: ticks on cycles 3,6,9,12
    add(1,1,0,0,0,  0,0,0); add(1,1,0,0,0,  0,0,0); add(1,1,0,0,0,  0,1,0);
    add(1,1,0,0,0,  1,0,0); add(1,1,0,0,0,  1,0,0); add(1,1,0,0,0,  1,1,0);
    add(1,1,0,0,0,  2,0,0); add(1,1,0,0,0,  2,0,0); add(1,1,0,0,0,  2,1,0);
    add(1,1,0,0,0,  3,0,0); add(1,1,0,0,0,  3,0,0); add(1,1,0,0,0,  3,1,0);
    add(1,1,0,0,0,  4,0,0);
    // load 14, then two up ticks across the top boundary
    add(1,1,0,1,14, 14,0,0);
    add(1,1,0,0,0,  14,1,0);
    add(1,1,0,0,0,  15,0,SAT);
    add(1,1,0,0,0,  15,0,0);
    add(1,1,0,0,0,  15,1,0);
    add(1,1,0,0,0,  sat15_or_0,0,!SAT);
    // load 0, then one down tick across the bottom boundary
    add(1,0,0,1,0,  0,0,0);
    add(1,0,0,0,0,  0,1,0);
    add(1,0,0,0,0,  dn_val,0,!SAT);
    add(1,0,0,0,0,  dn_val,0,0);
    add(1,0,0,0,0,  dn_val,1,0);
    // clear and load together on the tick cycle: clear wins, period restarts
    add(1,0,1,1,7,  0,0,0);
    add(1,1,0,0,0,  0,0,0);
    add(1,1,0,0,0,  0,0,0);
    add(1,1,0,0,0,  0,1,0);
    add(1,1,0,0,0,  1,0,0);
    // count_e low: tick still runs, count holds
    add(0,1,0,0,0,  1,0,0);
    add(0,1,0,0,0,  1,1,0);
    add(0,1,0,0,0,  1,0,0);
    // load 9 ahead of the asynchronous reset check
    add(0,1,0,1,9,  9,0,0);

    reset = 1'b0; count_e = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
    load_val = '0; count_e_b = 1'b0;
    cyc(); cyc();
    chk("reset_count", count, 0);
    chk("reset_tick",  tick, 0);
    chk("reset_wrap",  wrap, 0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      count_e = vecs[i].ce; up_dn = vecs[i].ud; clear = vecs[i].cl;
      load = vecs[i].ld; load_val = vecs[i].lv;
      cyc();
      chk($sformatf("v%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("v%0d_tick",  i), tick,  vecs[i].e_tick);
      chk($sformatf("v%0d_wrap",  i), wrap,  vecs[i].e_wrap);
    end

    // asynchronous reset between edges clears count without a clock edge
    load = 1'b0; count_e = 1'b1; up_dn = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_count", count, 0);
    chk("async_reset_tick",  tick, 0);
    cyc();
    chk("held_reset_count", count, 0);
    #3;
    reset = 1'b1;

    // after release: DIV=3 first tick on the 3rd edge; DIV=1 counts with count_e 1,0,1,1
    b_ce   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    b_cnt  = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3};
    a_tick = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    a_cnt  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
    for (int k = 0; k < 5; k++) begin
      count_e_b = b_ce[k];
      cyc();
      chk($sformatf("rel%0d_a_tick",  k), tick,  a_tick[k]);
      chk($sformatf("rel%0d_a_count", k), count, a_cnt[k]);
      chk($sformatf("rel%0d_b_tick",  k), tick_b, 1);
      chk($sformatf("rel%0d_b_count", k), count_b, b_cnt[k]);
      chk($sformatf("rel%0d_b_wrap",  k), wrap_b, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
